key_event_arbiter: RTL and testbench
====================================

Name: key_event_arbiter

Overview:
- Sits between the per-button EdgeDebouncer instances (one per board button, all timed from BigClockDiv's CLK_slice) and the Sudoku game FSM.
- Latches one-cycle debounced press pulses from N buttons and shares a single key-event channel between them using round-robin arbitration.
- Buffers granted events in a small FIFO and presents them on a valid/ready handshake.
- Optionally generates auto-repeat events for a held key.

Parameters:
N_KEYS, 5, number of button requesters (up/down/left/right/enter)
CODE_W, 3, width of key code; must satisfy 2**CODE_W >= N_KEYS
FIFO_DEPTH, 4, event FIFO entries (power of 2)
REPEAT_DELAY, 50, CLK_slice rising edges a key must be held before first repeat
REPEAT_RATE, 10, CLK_slice rising edges between subsequent repeats

Ports:
CLK  in  1  system clock, 100 MHz
RST  in  1  reset; one clock; reset is synchronous and active-high
CLK_slice  in  1  slow slice signal from BigClockDiv; only its rising edge (sampled on CLK) is used
KEY_pulse  in  N_KEYS  one-CLK press pulses from EdgeDebouncer, bit i = key i
KEY_level  in  N_KEYS  debounced held level per key (used only with auto-repeat)
EV_valid  out  1  FIFO head holds an event
EV_code  out  CODE_W  key index of head event
EV_repeat  out  1  head event is an auto-repeat
EV_ready  in  1  consumer accepts head this cycle
OVF  out  1  sticky: a press was merged or dropped
OVF_clr  in  1  clears OVF

Behaviour:
- Reset (RST=1 at a CLK edge):
  - pending[] = 0, rr_ptr = 0, FIFO empty.
  - EV_valid = 0, EV_code = 0, EV_repeat = 0, OVF = 0, repeat tracker idle.
  - Reset mid-operation discards all queued and pending events.
  - Reset has priority over all other inputs.
- Pending latch:
  - pending[i] is set on the edge where KEY_pulse[i]=1.
  - It is cleared on the edge where key i is granted.
  - If a grant and a new pulse hit the same key at the same edge, pending stays 1 and the new press is kept.
  - A pulse arriving while pending[i] is already 1 and not being granted is merged, and OVF is set.
- Arbiter:
  - Combinational each cycle.
  - If any pending bit is set and the FIFO is not full, grant the lowest index j >= rr_ptr, wrapping modulo N_KEYS.
  - On grant: push {repeat_flag, j}, clear pending[j], and set rr_ptr = (j+1) mod N_KEYS.
  - At most one grant per cycle.
  - While the FIFO is full there is no grant; pending bits hold and are not lost.
- FIFO:
  - Show-ahead: EV_code/EV_repeat are valid whenever EV_valid=1.
  - Pop when EV_valid & EV_ready; EV_ready while EV_valid=0 is ignored.
  - "Full" is evaluated before the current cycle's pop, so no push happens on a full FIFO even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full keeps the count unchanged.
  - Read and write pointers wrap at FIFO_DEPTH.
- Latency, idle FIFO:
  - KEY_pulse high during cycle t → pending set at edge t+1.
  - Push at edge t+2 → EV_valid=1 during cycle t+2.
- Simultaneous pulses on keys 0 and 3 with rr_ptr=0 → events 0 then 3 on consecutive cycles.
- OVF:
  - Set by a merged press or a repeat request dropped by the tracker.
  - Cleared by OVF_clr=1; set takes priority when both occur in the same cycle.
- CLK_slice edge detect: slice_tick = CLK_slice & ~CLK_slice_d, one register stage.

Optional Feature:
- Macro AUTOREPEAT_EN, when defined:
  - A single tracker holds the key index of the most recently granted non-repeat event and a tick counter.
  - The counter increments on slice_tick while KEY_level[key]=1.
  - When the count reaches REPEAT_DELAY, the tracker sets pending[key] with repeat_flag=1 and reloads for REPEAT_RATE, repeating indefinitely.
  - If pending[key] is already set at that point, the repeat is dropped and OVF is set.
  - KEY_level[key]=0 or a new non-repeat grant of any key retargets or idles the tracker and clears the counter.
- Macro undefined:
  - No tracker; KEY_level is ignored.
  - EV_repeat is constant 0 and the repeat bit is not stored in the FIFO.

Test Plan:
- RST=1 for 3 cycles mid-stream with 2 events queued → after release EV_valid=0, OVF=0, and the next pulse on key 2 yields EV_code=2.
- Single KEY_pulse[4] at cycle 10, EV_ready=1 → EV_valid=1 with EV_code=4 during cycle 12 only, then low.
- KEY_pulse=5'b11111 in one cycle, EV_ready=0 → FIFO holds codes 0,1,2,3 and key 4 stays pending. Then EV_ready=1 → codes 0,1,2,3,4 in order, no OVF.
- Key 1 pulsed twice 3 cycles apart while FIFO full → one event for key 1, OVF=1. OVF_clr → OVF=0.
- Round-robin fairness: keys 0 and 1 re-pulsed each cycle for 20 cycles, EV_ready=1 → codes alternate 0,1,0,1…
- AUTOREPEAT_EN defined, REPEAT_DELAY=3, REPEAT_RATE=2, key 3 held → one event with EV_repeat=0, then repeats (EV_repeat=1) on the 3rd, 5th and 7th slice ticks. On release, no further events.

Source files
------------

// File: rtl/key_event_arbiter.sv
// key_event_arbiter
// Collects one-cycle debounced press pulses from N_KEYS buttons, shares a
// single key-event channel between them with round-robin arbitration, and
// queues granted events in a small show-ahead FIFO drained over valid/ready.
//
// Optional feature: define AUTOREPEAT_EN to enable a single auto-repeat
// tracker that re-requests the most recently pressed key while it is held.
// Without it, KEY_level is ignored and EV_repeat is tied to 0.
//
// Ports:
//   CLK        system clock
//   RST        synchronous active-high reset
//   CLK_slice  slow slice signal, rising edge (sampled on CLK) is a tick
//   KEY_pulse  one-CLK press pulses, bit i = key i
//   KEY_level  debounced held level per key (auto-repeat only)
//   EV_valid   FIFO head holds an event
//   EV_code    key index of head event
//   EV_repeat  head event is an auto-repeat
//   EV_ready   consumer accepts head this cycle
//   OVF        sticky: a press was merged or a repeat was dropped
//   OVF_clr    clears OVF (a simultaneous set wins)
module key_event_arbiter #(
    parameter int N_KEYS       = 5,
    parameter int CODE_W       = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLK_slice,
    input  logic [N_KEYS-1:0] KEY_pulse,
    input  logic [N_KEYS-1:0] KEY_level,
    output logic              EV_valid,
    output logic [CODE_W-1:0] EV_code,
    output logic              EV_repeat,
    input  logic              EV_ready,
    output logic              OVF,
    input  logic              OVF_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef AUTOREPEAT_EN
    localparam int ENTRY_W = CODE_W + 1;
    localparam int RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCNT_W  = $clog2(RMAX + 1);
`else
    localparam int ENTRY_W = CODE_W;
`endif

    logic [N_KEYS-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               slice_d_q;

    logic               slice_tick_s;
    logic               fifo_full_s;
    logic               grant_found_s;
    logic [CODE_W-1:0]  grant_idx_s;
    logic [CODE_W-1:0]  cand_s;
    logic [N_KEYS-1:0]  grant_mask_s;
    logic               push_s, pop_s, ovf_set_s;
    logic [ENTRY_W-1:0] head_s;

    assign slice_tick_s = CLK_slice & ~slice_d_q;

`ifdef AUTOREPEAT_EN
    logic [N_KEYS-1:0]  pending_rep_q, pending_rep_d;
    logic               trk_active_q, trk_active_d;
    logic [CODE_W-1:0]  trk_key_q, trk_key_d;
    logic [RCNT_W-1:0]  trk_cnt_q, trk_cnt_d;
    logic               trk_first_q, trk_first_d;
    logic [RCNT_W-1:0]  trk_thr_s, trk_inc_s;
    logic               rep_req_s;

    // Repeat tracker: follows the latest non-repeat grant and counts held ticks.
    always_comb begin
        trk_active_d = trk_active_q;
        trk_key_d    = trk_key_q;
        trk_cnt_d    = trk_cnt_q;
        trk_first_d  = trk_first_q;
        rep_req_s    = 1'b0;
        trk_thr_s    = trk_first_q ? RCNT_W'(REPEAT_DELAY) : RCNT_W'(REPEAT_RATE);
        trk_inc_s    = trk_cnt_q + RCNT_W'(1);
        if (grant_found_s && !pending_rep_q[grant_idx_s]) begin
            trk_active_d = 1'b1;
            trk_key_d    = grant_idx_s;
            trk_cnt_d    = '0;
            trk_first_d  = 1'b1;
        end else if (trk_active_q) begin
            if (!KEY_level[trk_key_q]) begin
                trk_active_d = 1'b0;
                trk_cnt_d    = '0;
            end else if (slice_tick_s) begin
                if (trk_inc_s == trk_thr_s) begin
                    rep_req_s   = 1'b1;
                    trk_cnt_d   = '0;
                    trk_first_d = 1'b0;
                end else begin
                    trk_cnt_d = trk_inc_s;
                end
            end else begin
                trk_cnt_d = trk_cnt_q;
            end
        end else begin
            trk_cnt_d = trk_cnt_q;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{KEY_level, slice_tick_s};
`endif

    // Round-robin grant, pending latch, FIFO pointers and OVF next state.
    always_comb begin
        pending_d     = pending_q;
        rr_ptr_d      = rr_ptr_q;
        fifo_mem_d    = fifo_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        grant_mask_s  = '0;
        ovf_set_s     = 1'b0;
        fifo_full_s   = (count_q == CNT_W'(FIFO_DEPTH));

        // Search starts at rr_ptr and wraps; first pending key wins.
        for (int k = 0; k < N_KEYS; k++) begin
            cand_s = CODE_W'((int'(rr_ptr_q) + k) % N_KEYS);
            if (!grant_found_s && !fifo_full_s && pending_q[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (grant_found_s) begin
            grant_mask_s[grant_idx_s] = 1'b1;
            rr_ptr_d = (grant_idx_s == CODE_W'(N_KEYS - 1)) ? '0 : grant_idx_s + CODE_W'(1);
        end else begin
            grant_mask_s = '0;
        end

        // A new press on a key being granted this edge survives the clear.
        if (|(KEY_pulse & pending_q & ~grant_mask_s)) begin
            ovf_set_s = 1'b1;
        end else begin
            ovf_set_s = 1'b0;
        end
        pending_d = (pending_q & ~grant_mask_s) | KEY_pulse;

`ifdef AUTOREPEAT_EN
        pending_rep_d = pending_rep_q & ~KEY_pulse;
        if (rep_req_s) begin
            if (pending_q[trk_key_q] && !grant_mask_s[trk_key_q]) begin
                ovf_set_s = 1'b1;
            end else if (!KEY_pulse[trk_key_q]) begin
                pending_d[trk_key_q]     = 1'b1;
                pending_rep_d[trk_key_q] = 1'b1;
            end else begin
                // A real press at the same edge takes the slot as non-repeat.
                pending_rep_d[trk_key_q] = 1'b0;
            end
        end else begin
            pending_rep_d = pending_rep_d;
        end
`endif

        push_s = grant_found_s;
        pop_s  = (count_q != '0) && EV_ready;
        if (push_s) begin
`ifdef AUTOREPEAT_EN
            fifo_mem_d[wr_ptr_q] = {pending_rep_q[grant_idx_s], grant_idx_s};
`else
            fifo_mem_d[wr_ptr_q] = grant_idx_s;
`endif
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (OVF_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            slice_d_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
`ifdef AUTOREPEAT_EN
            pending_rep_q <= '0;
            trk_active_q  <= 1'b0;
            trk_key_q     <= '0;
            trk_cnt_q     <= '0;
            trk_first_q   <= 1'b0;
`endif
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            slice_d_q  <= CLK_slice;
            fifo_mem_q <= fifo_mem_d;
`ifdef AUTOREPEAT_EN
            pending_rep_q <= pending_rep_d;
            trk_active_q  <= trk_active_d;
            trk_key_q     <= trk_key_d;
            trk_cnt_q     <= trk_cnt_d;
            trk_first_q   <= trk_first_d;
`endif
        end
    end

    assign head_s   = fifo_mem_q[rd_ptr_q];
    assign EV_valid = (count_q != '0);
    assign EV_code  = EV_valid ? head_s[CODE_W-1:0] : '0;
`ifdef AUTOREPEAT_EN
    assign EV_repeat = EV_valid ? head_s[CODE_W] : 1'b0;
`else
    assign EV_repeat = 1'b0;
`endif
    assign OVF = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed self-checking bench for key_event_arbiter.
// Popped events are logged as code + 8*repeat + 16*slice_ticks_sent.
module tb_key_event_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CLK_slice;
    logic [4:0] KEY_pulse;
    logic [4:0] KEY_level;
    logic       EV_valid;
    logic [2:0] EV_code;
    logic       EV_repeat;
    logic       EV_ready;
    logic       OVF;
    logic       OVF_clr;

    int total = 0;
    int bad   = 0;
    int ev_q[$];
    int ticks_sent = 0;

    always #5 CLK = ~CLK;

    key_event_arbiter #(
        .N_KEYS(5), .CODE_W(3), .FIFO_DEPTH(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut (
        .CLK(CLK), .RST(RST), .CLK_slice(CLK_slice),
        .KEY_pulse(KEY_pulse), .KEY_level(KEY_level),
        .EV_valid(EV_valid), .EV_code(EV_code), .EV_repeat(EV_repeat),
        .EV_ready(EV_ready), .OVF(OVF), .OVF_clr(OVF_clr)
    );

    // Event logger: records every accepted head.
    always @(negedge CLK) begin
        if (!RST && EV_valid === 1'b1 && EV_ready === 1'b1) begin
            ev_q.push_back(int'(EV_code) + ((EV_repeat === 1'b1) ? 8 : 0) + ticks_sent * 16);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; CLK_slice = 1'b0; KEY_pulse = '0; KEY_level = '0;
        EV_ready = 1'b0; OVF_clr = 1'b0;
        cyc(2);
        RST = 1'b0;
        ev_q.delete();
        ticks_sent = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b0 || EV_code !== 3'd0 || EV_repeat !== 1'b0 || OVF !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b code=%0d rep=%b ovf=%b, want 0 0 0 0",
                     EV_valid, EV_code, EV_repeat, OVF);
        end
        KEY_pulse = 5'b00011; cyc(1); KEY_pulse = '0; cyc(4);
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b1 || EV_code !== 3'd0) begin
            bad++;
            $display("FAIL reset_queued: got valid=%b code=%0d, want 1 0", EV_valid, EV_code);
        end
        RST = 1'b1; cyc(3); RST = 1'b0;
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b0 || OVF !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got valid=%b ovf=%b, want 0 0", EV_valid, OVF);
        end
        cyc(4);
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard: got valid=%b, want 0", EV_valid);
        end
        ev_q.delete();
        EV_ready = 1'b1; KEY_pulse = 5'b00100; cyc(1); KEY_pulse = '0; cyc(5);
        total++;
        if (ev_q.size() != 1 || ev_q[0] != 2) begin
            bad++;
            $display("FAIL reset_next: got n=%0d first=%0d, want n=1 first=2",
                     ev_q.size(), (ev_q.size() > 0) ? ev_q[0] : -1);
        end
        // rr_ptr restarts at 0: key 0 before key 4.
        do_reset();
        EV_ready = 1'b1; KEY_pulse = 5'b10001; cyc(1); KEY_pulse = '0; cyc(6);
        total++;
        if (ev_q.size() != 2 || ev_q[0] != 0 || ev_q[1] != 4) begin
            bad++;
            $display("FAIL reset_rr: got n=%0d, want codes 0,4", ev_q.size());
        end
    endtask

    task automatic test_single();
        do_reset();
        EV_ready = 1'b1; KEY_pulse = 5'b10000;
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b0) begin
            bad++; $display("FAIL single_t0: got valid=%b, want 0", EV_valid);
        end
        cyc(1); KEY_pulse = '0;
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b0) begin
            bad++; $display("FAIL single_t1: got valid=%b, want 0", EV_valid);
        end
        cyc(1);
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b1 || EV_code !== 3'd4 || EV_repeat !== 1'b0) begin
            bad++;
            $display("FAIL single_t2: got valid=%b code=%0d rep=%b, want 1 4 0",
                     EV_valid, EV_code, EV_repeat);
        end
        cyc(1);
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b0) begin
            bad++; $display("FAIL single_t3: got valid=%b, want 0", EV_valid);
        end
    endtask

    task automatic test_fill();
        int exp_codes[5] = '{0, 1, 2, 3, 4};
        do_reset();
        KEY_pulse = 5'b11111; cyc(1); KEY_pulse = '0; cyc(8);
        @(negedge CLK);
        total++;
        if (EV_valid !== 1'b1 || EV_code !== 3'd0) begin
            bad++; $display("FAIL fill_head: got valid=%b code=%0d, want 1 0", EV_valid, EV_code);
        end
        ev_q.delete();
        EV_ready = 1'b1; cyc(10); EV_ready = 1'b0;
        total++;
        if (ev_q.size() != 5) begin
            bad++; $display("FAIL fill_count: got %0d events, want 5", ev_q.size());
        end
        for (int i = 0; i < 5 && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] != exp_codes[i]) begin
                bad++; $display("FAIL fill_order[%0d]: got %0d, want %0d", i, ev_q[i], exp_codes[i]);
            end
        end
        total++;
        if (OVF !== 1'b0) begin
            bad++; $display("FAIL fill_ovf: got %b, want 0", OVF);
        end
    endtask

    task automatic test_ovf();
        int exp_codes[5] = '{0, 2, 3, 4, 1};
        do_reset();
        KEY_pulse = 5'b11101; cyc(1); KEY_pulse = '0; cyc(6);
        @(negedge CLK);
        total++;
        if (OVF !== 1'b0) begin
            bad++; $display("FAIL ovf_pre: got %b, want 0", OVF);
        end
        KEY_pulse = 5'b00010; cyc(1); KEY_pulse = '0; cyc(2);
        KEY_pulse = 5'b00010; cyc(1); KEY_pulse = '0; cyc(1);
        @(negedge CLK);
        total++;
        if (OVF !== 1'b1) begin
            bad++; $display("FAIL ovf_merge: got %b, want 1", OVF);
        end
        ev_q.delete();
        EV_ready = 1'b1; cyc(10); EV_ready = 1'b0;
        total++;
        if (ev_q.size() != 5) begin
            bad++; $display("FAIL ovf_count: got %0d events, want 5", ev_q.size());
        end
        for (int i = 0; i < 5 && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] != exp_codes[i]) begin
                bad++; $display("FAIL ovf_order[%0d]: got %0d, want %0d", i, ev_q[i], exp_codes[i]);
            end
        end
        total++;
        if (OVF !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky: got %b, want 1", OVF);
        end
        OVF_clr = 1'b1; cyc(1); OVF_clr = 1'b0;
        @(negedge CLK);
        total++;
        if (OVF !== 1'b0) begin
            bad++; $display("FAIL ovf_clr: got %b, want 0", OVF);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        EV_ready = 1'b1;
        KEY_pulse = 5'b00011; cyc(20); KEY_pulse = '0; cyc(6); EV_ready = 1'b0;
        total++;
        if (ev_q.size() < 18 || ev_q.size() > 24) begin
            bad++; $display("FAIL rr_count: got %0d events, want 18..24", ev_q.size());
        end
        for (int i = 0; i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] != (i % 2)) begin
                bad++; $display("FAIL rr_alt[%0d]: got %0d, want %0d", i, ev_q[i], i % 2);
            end
        end
        total++;
        if (OVF !== 1'b1) begin
            bad++; $display("FAIL rr_ovf: got %b, want 1", OVF);
        end
    endtask

    task automatic test_autorepeat();
`ifdef AUTOREPEAT_EN
        int exp_ev[$] = '{3, 3 + 8 + 3 * 16, 3 + 8 + 5 * 16, 3 + 8 + 7 * 16};
`else
        int exp_ev[$] = '{3};
`endif
        do_reset();
        EV_ready = 1'b1; KEY_level = 5'b01000; cyc(1);
        KEY_pulse = 5'b01000; cyc(1); KEY_pulse = '0; cyc(4);
        for (int t = 0; t < 8; t++) begin
            CLK_slice = 1'b1; ticks_sent++; cyc(1);
            CLK_slice = 1'b0; cyc(5);
        end
        KEY_level = '0; cyc(2);
        for (int t = 0; t < 4; t++) begin
            CLK_slice = 1'b1; ticks_sent++; cyc(1);
            CLK_slice = 1'b0; cyc(5);
        end
        total++;
        if (ev_q.size() != exp_ev.size()) begin
            bad++; $display("FAIL rep_count: got %0d events, want %0d", ev_q.size(), exp_ev.size());
        end
        for (int i = 0; i < exp_ev.size() && i < ev_q.size(); i++) begin
            total++;
            if (ev_q[i] != exp_ev[i]) begin
                bad++; $display("FAIL rep_ev[%0d]: got %0d, want %0d", i, ev_q[i], exp_ev[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_ovf();
        test_round_robin();
        test_autorepeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
